// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory access path: arbiter FSM encoding,
// requester port indices and the default memory size.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DBG = 1;

    localparam int unsigned DEFAULT_MEM_BYTES = 1024;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter. Only a tie needs deciding: round-robin hands it to
// the port that did not win last time, fixed priority always favours the CPU.
module rr_arbiter2
    import riscv_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       prio_mode,
    output logic [1:0] grant
);

    // One-hot grant; a lone requester always wins.
    always_comb begin
        grant = '0;
        if (req[PORT_CPU] && req[PORT_DBG]) begin
            if (prio_mode || last_grant) begin
                grant[PORT_CPU] = 1'b1;
            end else begin
                grant[PORT_DBG] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous data memory between the CPU load/store
// unit (port 0) and the debug/program loader (port 1). Every transaction takes
// exactly three cycles: latch, memory access, response.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a request; picks a winner and latches its command
//   ACCESS | memory strobe is out (unless the address is out of range)
//   RESP   | memory data is valid; ack/err/rdata registered for the winner
//
// ack, err and rdata become visible in the cycle after leaving RESP, i.e. while
// the FSM is already back in IDLE. A requester that has seen its ack must drop
// req before the next edge, otherwise it is sampled as a fresh request.
module dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [DATA_W/8-1:0]   be0,
    input  logic [DATA_W/8-1:0]   be1,
    output logic [1:0]            ack,
    output logic [1:0]            err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-3:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata
);

    arb_state_t            state;
    logic                  last_grant;
    logic                  win_q;
    logic                  we_q;
    logic                  oor_q;

    logic [1:0]            grant;
    logic                  prio_mode;
    logic                  sel;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [DATA_W/8-1:0]   sel_be;
    logic                  sel_in_range;

    assign prio_mode = (PRIO_MODE != 0);

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .prio_mode  (prio_mode),
        .grant      (grant)
    );

    // Command of the granted port; only ever consumed by the IDLE latch, so
    // req never reaches mem_* without a register in between.
    always_comb begin
        sel          = grant[PORT_DBG];
        sel_we       = we[sel];
        sel_addr     = sel ? addr1  : addr0;
        sel_wdata    = sel ? wdata1 : wdata0;
        sel_be       = sel ? be1    : be0;
        // Full byte address is compared, low bits included.
        sel_in_range = (sel_addr < ADDR_W'(MEM_BYTES));
    end

    // Transaction FSM with command latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            ack        <= '0;
            err        <= '0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            ack    <= '0;
            err    <= '0;
            rdata  <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        win_q      <= sel;
                        last_grant <= sel;
                        we_q       <= sel_we;
                        oor_q      <= !sel_in_range;
                        mem_addr   <= sel_addr[ADDR_W-1:2];
                        mem_wdata  <= sel_wdata;
                        mem_be     <= sel_be;
                        mem_en     <= sel_in_range;
                        mem_we     <= sel_in_range && sel_we;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    ack[win_q] <= 1'b1;
                    err[win_q] <= oor_q;
                    if (!we_q && !oor_q) begin
                        rdata <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a small
// synchronous byte-enabled memory, and a fixed-priority instance sharing the
// same requester stimulus with a constant read-data source.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  be0, be1;

    logic [1:0]  ack, err;
    logic [31:0] rdata, mem_wdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'd0;

    logic [1:0]  ack_p, err_p;
    logic [31:0] rdata_p, mem_wdata_p;
    logic        mem_en_p, mem_we_p;
    logic [29:0] mem_addr_p;
    logic [3:0]  mem_be_p;
    logic [31:0] mem_rdata_p;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata_p = 32'h5A5A5A5A;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .ack(ack), .err(err), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .ack(ack_p), .err(err_p), .rdata(rdata_p),
        .mem_en(mem_en_p), .mem_we(mem_we_p), .mem_addr(mem_addr_p),
        .mem_wdata(mem_wdata_p), .mem_be(mem_be_p), .mem_rdata(mem_rdata_p)
    );

    // Synchronous memory model: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[2]   = 32'd99;
        mem[255] = 32'h0BAD0FF1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_ack",   32'(ack),       32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_rdata", rdata,          32'd0);
        chk("rst_en",    32'(mem_en),    32'd0);
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_wdata", mem_wdata,      32'd0);
        chk("rst_be",    32'(mem_be),    32'd0);

        // single load, port 0, addr 8
        req = 2'b01; we = 2'b00; addr0 = 32'd8; be0 = 4'hF;
        tick();
        chk("ld_en",     32'(mem_en),    32'd1);
        chk("ld_memwe",  32'(mem_we),    32'd0);
        chk("ld_addr",   32'(mem_addr),  32'd2);
        chk("ld_ack_a",  32'(ack),       32'd0);
        tick();
        chk("ld_en_off", 32'(mem_en),    32'd0);
        chk("ld_ack_r",  32'(ack),       32'd0);
        tick();
        chk("ld_ack",    32'(ack),       32'b01);
        chk("ld_rdata",  rdata,          32'd99);
        chk("ld_err",    32'(err),       32'd0);
        req = 2'b00;
        tick();
        chk("ld_ack_end", 32'(ack),      32'd0);

        // store port 1, full word, addr 12
        req = 2'b10; we = 2'b10; addr1 = 32'd12; wdata1 = 32'hDEADBEEF; be1 = 4'hF;
        tick();
        chk("st_en",     32'(mem_en),    32'd1);
        chk("st_memwe",  32'(mem_we),    32'd1);
        chk("st_addr",   32'(mem_addr),  32'd3);
        chk("st_wdata",  mem_wdata,      32'hDEADBEEF);
        chk("st_be",     32'(mem_be),    32'hF);
        repeat (2) tick();
        chk("st_ack",    32'(ack),       32'b10);
        chk("st_rdata",  rdata,          32'd0);
        req = 2'b00; we = 2'b00;
        tick();

        // load it back on port 0
        req = 2'b01; addr0 = 32'd12;
        repeat (3) tick();
        chk("st_ld_ack",   32'(ack),     32'b01);
        chk("st_ld_rdata", rdata,        32'hDEADBEEF);
        req = 2'b00;
        tick();

        // partial store (low half) then reload
        req = 2'b10; we = 2'b10; wdata1 = 32'h11223344; be1 = 4'h3;
        tick();
        chk("pst_be",    32'(mem_be),    32'h3);
        repeat (2) tick();
        chk("pst_ack",   32'(ack),       32'b10);
        req = 2'b00; we = 2'b00;
        tick();
        req = 2'b01;
        repeat (3) tick();
        chk("pst_rdata", rdata,          32'hDEAD3344);
        req = 2'b00;
        tick();

        // contention from a fresh reset: RR gives 0,1,0,1; priority gives 0 always
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11; we = 2'b00; addr0 = 32'd8; addr1 = 32'd12;
        wdata0 = 32'hCAFE0000; be0 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cnt_ack_a", 32'(ack), 32'd0);
            if (k == 0) begin
                chk("prio_en",    32'(mem_en_p),   32'd1);
                chk("prio_memwe", 32'(mem_we_p),   32'd0);
                chk("prio_addr",  32'(mem_addr_p), 32'd2);
                chk("prio_wdata", mem_wdata_p,     32'hCAFE0000);
                chk("prio_be",    32'(mem_be_p),   32'hF);
            end
            tick();
            chk("cnt_ack_r", 32'(ack), 32'd0);
            tick();
            chk("cnt_ack",   32'(ack),   (k % 2 == 0) ? 32'b01 : 32'b10);
            chk("cnt_rdata", rdata,      (k % 2 == 0) ? 32'd99 : 32'hDEAD3344);
            chk("prio_ack",  32'(ack_p), 32'b01);
            chk("prio_err",  32'(err_p), 32'd0);
            if (k == 0) chk("prio_rdata", rdata_p, 32'h5A5A5A5A);
        end
        req = 2'b00;
        tick();
        chk("cnt_ack_end", 32'(ack), 32'd0);

        // out of range load, port 1, addr 1024
        req = 2'b10; addr1 = 32'd1024;
        tick();
        chk("oor_en",    32'(mem_en),    32'd0);
        chk("oor_memwe", 32'(mem_we),    32'd0);
        tick();
        chk("oor_en2",   32'(mem_en),    32'd0);
        tick();
        chk("oor_ack",   32'(ack),       32'b10);
        chk("oor_err",   32'(err),       32'b10);
        chk("oor_rdata", rdata,          32'd0);
        req = 2'b00;
        tick();
        chk("oor_err_end", 32'(err),     32'd0);

        // last in-range word, port 1, addr 1020
        req = 2'b10; addr1 = 32'd1020;
        tick();
        chk("top_en",    32'(mem_en),    32'd1);
        chk("top_addr",  32'(mem_addr),  32'd255);
        repeat (2) tick();
        chk("top_ack",   32'(ack),       32'b10);
        chk("top_err",   32'(err),       32'd0);
        chk("top_rdata", rdata,          32'h0BAD0FF1);
        req = 2'b00;
        tick();

        // async reset during ACCESS of a port 0 load
        req = 2'b01; addr0 = 32'd8;
        tick();
        chk("rm_en_pre", 32'(mem_en),    32'd1);
        #2;
        rst = 1'b1; req = 2'b00;
        #1;
        chk("rm_en",     32'(mem_en),    32'd0);
        chk("rm_ack",    32'(ack),       32'd0);
        chk("rm_addr",   32'(mem_addr),  32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("rm_noack1", 32'(ack),       32'd0);
        tick();
        chk("rm_noack2", 32'(ack),       32'd0);
        tick();
        chk("rm_noack3", 32'(ack),       32'd0);
        req = 2'b11; addr0 = 32'd8; addr1 = 32'd12;
        tick();
        chk("rm_tie_addr", 32'(mem_addr), 32'd2);
        repeat (2) tick();
        chk("rm_tie_ack",  32'(ack),      32'b01);
        chk("rm_tie_rd",   rdata,         32'd99);
        req = 2'b00;
        tick();

        // early req drop; command change after latch is ignored
        req = 2'b01; addr0 = 32'd8;
        tick();
        req = 2'b00; addr0 = 32'd12;
        tick();
        chk("ed_ack_r",  32'(ack),       32'd0);
        tick();
        chk("ed_ack",    32'(ack),       32'b01);
        chk("ed_rdata",  rdata,          32'd99);
        tick();
        chk("ed_ack_end", 32'(ack),      32'd0);
        chk("ed_en_end",  32'(mem_en),   32'd0);
        tick();
        chk("ed_no2_en",  32'(mem_en),   32'd0);
        tick();
        chk("ed_no2_ack", 32'(ack),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory of the RISC-V single-cycle core between two requesters.
  - Port 0: the CPU load/store unit, stalled via its req/ack handshake.
  - Port 1: the debug/program loader used to preload and inspect memory after reset.
- Sits between those requesters and the synchronous data memory (1-cycle read latency).
- Performs arbitration, command latching, response routing and address-range checking.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports.
- DATA_W, 32, data width; must be 32. byte-enable width is DATA_W/8.
- MEM_BYTES, 1024, memory size in bytes; addresses >= MEM_BYTES are out of range.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-port request; held high until ack
- we  in  2  per-port write enable (1 = store)
- addr0, addr1  in  ADDR_W  per-port byte address
- wdata0, wdata1  in  DATA_W  per-port store data
- be0, be1  in  4  per-port byte enables
- ack  out  2  one-cycle per-port completion pulse
- err  out  2  one-cycle per-port out-of-range flag, coincident with ack
- rdata  out  DATA_W  load data, valid only while an ack bit is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W-2  word address (latched addr[ADDR_W-1:2])
- mem_wdata  out  DATA_W  latched store data
- mem_be  out  4  latched byte enables
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset and default state is IDLE.
- Reset values:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - ack = 0, err = 0, rdata = 0, mem_en = 0, mem_we = 0.
  - mem_addr = 0, mem_wdata = 0, mem_be = 0.
- IDLE, any req bit high at the clock edge:
  - Pick the winner. Round-robin: the port not equal to last_grant wins a tie. PRIO_MODE=1: port 0 always wins a tie.
  - Latch the winner's we, addr, wdata and be; record the winner; update last_grant; go to ACCESS.
- ACCESS:
  - In range (addr < MEM_BYTES): mem_en=1; mem_we = latched we; mem_addr/mem_wdata/mem_be driven from latched values.
  - Out of range: mem_en=0, mem_we=0, and the error flag is latched.
  - Next state is RESP.
- RESP:
  - ack[winner]=1.
  - Load: rdata = mem_rdata.
  - Store: rdata = 0.
  - Out of range: err[winner]=1, rdata=0.
  - Next state is IDLE unconditionally.
- Timing:
  - Fixed latency: req sampled at edge E gives ack high in the cycle following edge E+2.
  - Throughput: one transaction per 3 cycles. A back-to-back req is re-sampled in IDLE.
- Address checks:
  - Latched addr[1:0] is ignored; alignment is the requester's responsibility.
  - Out-of-range check uses the full latched address.
- Requester behaviour:
  - Non-winning req stays pending and is served next.
  - Round-robin guarantees a persistent requester waits at most one transaction.
  - req dropped after being latched: the transaction still completes and ack still pulses.
  - req changes during ACCESS/RESP: ignored; only the latched command is used.
- Outputs: all registered or decoded from state. No combinational path from req to mem_*.
- Reset mid-transaction (any state): immediately return to IDLE with all outputs 0.
  - A memory write already strobed is not undone.
  - No ack is issued for the aborted transaction.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Port index constants PORT_CPU=0, PORT_DBG=1.
  - Default MEM_BYTES.
- Sub-module rr_arbiter2: inputs req[1:0], last_grant, prio_mode; output one-hot grant. Purely combinational.
- The FSM and command latches stay in dmem_arbiter.

Test Plan:
- Single load: after reset, memory word 2 = 32'd99; port 0 loads addr 8. Required: mem_en/mem_addr=2 one edge after sampling; ack[0] with rdata=99 the next cycle; err=0.
- Store then load: port 1 stores 32'hDEADBEEF, be=4'hF, addr 12; then port 0 loads addr 12. Required: mem_we=1 with mem_wdata=DEADBEEF; subsequent load returns DEADBEEF.
- Contention, PRIO_MODE=0: both req held for 4 transactions. Required grants 0,1,0,1, each ack 3 cycles apart. Repeat with PRIO_MODE=1 and port 0 req held: port 1 never acks while port 0 requests.
- Out of range: port 1 loads addr 1024. Required: mem_en stays 0; ack[1]=1 and err[1]=1 together; rdata=0.
- Reset mid-operation: assert rst asynchronously during ACCESS of a port 0 load. Required: ack/mem_en drop to 0 immediately; after release, state IDLE and port 0 wins the first tie.
- Early req drop: port 0 drops req the cycle after sampling. Required: ack[0] still pulses once; no second transaction.
